// File: rtl/sig_pipe_pkg.sv
// Shared types and constants for the sig_a/sig_b register pipeline.
package sig_pipe_pkg;

  // Deepest pipeline the slice chain is built for.
  localparam int unsigned SIG_PIPE_MAX_STAGES = 8;

  // Default field widths of the downstream split-assign stage.
  localparam int unsigned SIG_A_W_DEFAULT = 1;
  localparam int unsigned SIG_B_W_DEFAULT = 1;

  // Packed bus payload at default widths; sig_a occupies the MSBs.
  typedef struct packed {
    logic [SIG_A_W_DEFAULT-1:0] sig_a;
    logic [SIG_B_W_DEFAULT-1:0] sig_b;
  } sig_bundle_t;

  // Width of the packed {sig_a, sig_b} bus for arbitrary field widths.
  function automatic int unsigned sig_bundle_w(input int unsigned a_w, input int unsigned b_w);
    return a_w + b_w;
  endfunction

endpackage

// File: rtl/sig_pipe_slice.sv
// One skid-buffered register slice: registered ready, full throughput.
module sig_pipe_slice #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  logic         main_valid_q, main_valid_d;
  logic         skid_valid_q, skid_valid_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         accept;
  logic         take;

  // Upstream may only push while the skid register is free.
  assign in_ready_o  = !skid_valid_q;
  assign out_valid_o = main_valid_q;
  assign out_data_o  = main_q;

  assign accept = in_valid_i && !skid_valid_q;
  assign take   = main_valid_q && out_ready_i;

  // Next-state: refill main from skid first, otherwise from the input.
  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_d       = main_q;
    skid_d       = skid_q;
    if (flush_i) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (take) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d = in_data_i;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!main_valid_q) begin
        main_valid_d = 1'b1;
        main_d       = in_data_i;
      end else begin
        skid_valid_d = 1'b1;
        skid_d       = in_data_i;
      end
    end
  end

  // Slice state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q       <= '0;
      skid_q       <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
    end
  end

endmodule

// File: rtl/sig_pipe_stage.sv
// Packs {sig_a, sig_b} and carries it through STAGES skid-buffered slices.
module sig_pipe_stage
  import sig_pipe_pkg::*;
#(
  parameter int unsigned A_W    = 1,
  parameter int unsigned B_W    = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [A_W-1:0]                 in_sig_a,
  input  logic [B_W-1:0]                 in_sig_b,
  input  logic                           flush,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [A_W+B_W-1:0]             pipelined_signals,
  output logic [$clog2(2*STAGES+1)-1:0]  occupancy
);

  localparam int unsigned W     = sig_bundle_w(A_W, B_W);
  localparam int unsigned OCC_W = $clog2(2*STAGES+1);

  // Payload at this instance's field widths.
  typedef struct packed {
    logic [A_W-1:0] sig_a;
    logic [B_W-1:0] sig_b;
  } bundle_t;

  bundle_t          in_bundle;
  logic             valid_c [STAGES+1];
  logic             ready_c [STAGES+1];
  logic [W-1:0]     data_c  [STAGES+1];
  logic             in_fire;
  logic             out_fire;
  logic [OCC_W-1:0] occ_q, occ_d;

  // Pack with sig_a on the MSB side.
  assign in_bundle.sig_a = in_sig_a;
  assign in_bundle.sig_b = in_sig_b;

  assign valid_c[0]       = in_valid;
  assign data_c[0]        = W'(in_bundle);
  assign in_ready         = ready_c[0];
  assign ready_c[STAGES]  = out_ready;
  assign out_valid        = valid_c[STAGES];
  assign pipelined_signals = data_c[STAGES];

  // Slice chain; flush fans out to every slice.
  for (genvar s = 0; s < STAGES; s++) begin : g_slice
    sig_pipe_slice #(.W(W)) u_slice (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush_i     (flush),
      .in_valid_i  (valid_c[s]),
      .in_ready_o  (ready_c[s]),
      .in_data_i   (data_c[s]),
      .out_valid_o (valid_c[s+1]),
      .out_ready_i (ready_c[s+1]),
      .out_data_o  (data_c[s+1])
    );
  end

  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign occupancy = occ_q;

  // Beat count: flush wins, simultaneous in/out leaves it unchanged.
  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else if (in_fire && !out_fire) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (!in_fire && out_fire) begin
      occ_d = occ_q - OCC_W'(1);
    end
  end

  // Occupancy register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

endmodule

// File: tb/tb_sig_pipe_stage.sv
// Scoreboard bench for sig_pipe_stage (A_W=4, B_W=4, STAGES=2).
module tb_sig_pipe_stage;

  localparam int unsigned A_W    = 4;
  localparam int unsigned B_W    = 4;
  localparam int unsigned STAGES = 2;
  localparam int unsigned OCC_W  = $clog2(2*STAGES+1);
  localparam int unsigned CAP    = 2*STAGES;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [A_W-1:0]   in_sig_a = '0;
  logic [B_W-1:0]   in_sig_b = '0;
  logic             flush = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [7:0]       pipelined_signals;
  logic [OCC_W-1:0] occupancy;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_q[$];
  int         model_occ = 0;
  bit         stall_prev = 0;
  logic [7:0] held = '0;
  bit         flush_window = 0;
  bit         seen77 = 0;

  sig_pipe_stage #(.A_W(A_W), .B_W(B_W), .STAGES(STAGES)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_sig_a          (in_sig_a),
    .in_sig_b          (in_sig_b),
    .flush             (flush),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .pipelined_signals (pipelined_signals),
    .occupancy         (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Upstream keeps a stalled beat presented until it is taken.
  assert property (@(posedge clk) disable iff (!rst_n) (in_valid && !in_ready && !flush) |=> in_valid)
    else begin
      n_fail++;
      $display("FAIL in_valid_hold: valid dropped before acceptance at %0t", $time);
    end

  // Input tracker: records accepted beats and the expected beat count.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      model_occ = 0;
    end else begin
      chk("occupancy", 32'(occupancy), 32'(model_occ));
      chk("occ_bound", 32'(occupancy <= OCC_W'(CAP)), 32'd1);
      if (flush) begin
        exp_q.delete();
        model_occ = 0;
      end else begin
        if (in_valid && in_ready) begin
          exp_q.push_back({in_sig_a, in_sig_b});
          model_occ++;
        end
        if (out_valid && out_ready) model_occ--;
      end
    end
  end

  // Output monitor: order, stability under stall, no phantom beats.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 0;
    end else begin
      if (stall_prev && out_valid) chk("stable_under_stall", 32'(pipelined_signals), 32'(held));
      if (out_valid && out_ready) begin
        if (flush_window && pipelined_signals == 8'h77) seen77 = 1;
        chk("beat_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) chk("out_data", 32'(pipelined_signals), 32'(exp_q.pop_front()));
      end
      stall_prev = out_valid && !out_ready && !flush;
      held       = pipelined_signals;
    end
  end

  task automatic tick(output bit fire);
    fire = in_valid && in_ready && !flush && rst_n;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] d);
    in_sig_a = d[7:4];
    in_sig_b = d[3:0];
  endtask

  // Push n beats starting at d0 with out_ready low; bounded.
  task automatic fill(input logic [7:0] d0, input int n);
    bit f;
    int got = 0;
    logic [7:0] d = d0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(d);
    for (int i = 0; i < 20 && got < n; i++) begin
      tick(f);
      if (f) begin
        got++;
        d = d + 8'd1;
        drive(d);
      end
    end
    in_valid = 1'b0;
    chk("fill_count", 32'(got), 32'(n));
  endtask

  // Drain with out_ready high until empty; bounded.
  task automatic drain(input string name);
    bit f;
    out_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (!in_valid && exp_q.size() == 0 && !out_valid) break;
      tick(f);
      if (f) in_valid = 1'b0;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
    chk({name, "_occ"}, 32'(occupancy), 32'd0);
  endtask

  initial begin
    bit f;
    bit last_fire;
    int sent;
    int acc;
    int thr;
    int cyc;
    logic [7:0] d;

    // 1. Reset
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);
    chk("post_rst_data", 32'(pipelined_signals), 32'd0);
    chk("post_rst_occ", 32'(occupancy), 32'd0);

    // 2. Streaming latency
    out_ready = 1'b1;
    in_valid  = 1'b1;
    drive(8'h3C);
    tick(f);
    chk("stream_accept0", 32'(f), 32'd1);
    chk("stream_lat_valid0", 32'(out_valid), 32'd0);
    drive(8'hA5);
    tick(f);
    in_valid = 1'b0;
    chk("stream_lat_valid1", 32'(out_valid), 32'd1);
    chk("stream_first", 32'(pipelined_signals), 32'h3C);
    chk("stream_occ_peak", 32'(occupancy), 32'd2);
    tick(f);
    chk("stream_second", 32'(pipelined_signals), 32'hA5);
    chk("stream_valid2", 32'(out_valid), 32'd1);
    tick(f);
    chk("stream_empty", 32'(out_valid), 32'd0);

    // 3. Backpressure
    out_ready = 1'b0;
    in_valid  = 1'b1;
    d = 8'h01;
    drive(d);
    acc = 0;
    repeat (10) begin
      tick(f);
      if (f) begin
        acc++;
        d = d + 8'd1;
        drive(d);
      end
    end
    chk("bp_accepted", 32'(acc), 32'd4);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_occ", 32'(occupancy), 32'd4);
    chk("bp_oldest", 32'(pipelined_signals), 32'h01);
    drain("bp_drain");

    // 4. Random stall
    sent = 0;
    cyc = 0;
    last_fire = 0;
    thr = 70;
    in_valid = 1'b0;
    while (sent < 10000 && cyc < 60000) begin
      if (cyc % 1000 == 0) thr = (cyc / 1000 % 3 == 0) ? 95 : (cyc / 1000 % 3 == 1) ? 25 : 60;
      if (!in_valid || last_fire) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_sig_a = 4'($urandom);
        in_sig_b = 4'($urandom);
      end
      out_ready = ($urandom_range(0, 99) < thr);
      tick(f);
      last_fire = f;
      if (f) sent++;
      cyc++;
    end
    if (last_fire) in_valid = 1'b0;
    chk("random_sent", 32'(sent), 32'd10000);
    drain("random_drain");

    // 5. Flush
    fill(8'h11, 3);
    chk("flush_pre_occ", 32'(occupancy), 32'd3);
    in_valid = 1'b1;
    drive(8'h77);
    flush = 1'b1;
    tick(f);
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_occ", 32'(occupancy), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    flush_window = 1;
    out_ready = 1'b1;
    acc = 0;
    repeat (10) begin
      if (out_valid) acc++;
      tick(f);
    end
    flush_window = 0;
    chk("flush_no_output", 32'(acc), 32'd0);
    chk("flush_no_77", 32'(seen77), 32'd0);

    // 6. Async reset mid-stream
    fill(8'h31, 3);
    chk("arst_pre_occ", 32'(occupancy), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_occ", 32'(occupancy), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_data", 32'(pipelined_signals), 32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    drive(8'h5A);
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      tick(f);
      if (f) begin
        in_valid = 1'b0;
        acc = 1;
        break;
      end
    end
    chk("arst_accept", 32'(acc), 32'd1);
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) begin
        acc = 1;
        chk("arst_first_beat", 32'(pipelined_signals), 32'h5A);
        break;
      end
      tick(f);
    end
    chk("arst_out_seen", 32'(acc), 32'd1);
    drain("arst_drain");

    tick(f);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
